serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder: accepts two WIDTH-bit operands plus carry-in on a start pulse and adds them LSB-first, one bit per clock, through a single full-adder slice with a registered carry. It sits downstream of the combinational half-adder cell, consuming two instances of that cell to form its bit slice. It trades latency for area in the lab datapath. A start/busy/done handshake hands the result to the next stage.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1..32
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled on rising clk edge in IDLE or DONE
- a  input  WIDTH  operand A; captured when start is accepted
- b  input  WIDTH  operand B; captured when start is accepted
- cin  input  1  carry-in; captured when start is accepted
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result bits; held until the next completion
- cout  output  1  final carry; held with sum

## Operation
- Arithmetic: {cout,sum} = a + b + cin, exact (WIDTH+1 bits, no overflow loss).
- Bit slice: full adder built from two half-adder cells plus OR.
  - s = A0 ^ B0 ^ c
  - c_next = (A0 & B0) | (c & (A0 ^ B0))
- Internal state:
  - shift regs ra, rb (WIDTH)
  - result shift reg rs (WIDTH)
  - carry reg c
  - bit counter cnt of width $clog2(WIDTH+1)
- States: IDLE, ADD, DONE.
  - IDLE: if start, then ra<=a, rb<=b, c<=cin, cnt<=0, and go to ADD. Otherwise stay.
  - ADD, each cycle:
    - rs <= {s, rs[WIDTH-1:1]}
    - ra, rb shift right by 1, zero fill
    - c <= c_next
    - cnt <= cnt+1
  - ADD exit: when cnt == WIDTH-1 on this edge, load sum <= {s, rs[WIDTH-1:1]} and cout <= c_next, assert done, and go to DONE.
  - DONE: done deasserts at the next edge. If start is high at that edge, capture the new operands and go to ADD (back-to-back). Otherwise go to IDLE.
- start while in ADD: ignored; operands are not re-captured.
- a/b/cin may change freely after capture.
- Reset, including mid-ADD:
  - state = IDLE
  - busy = 0, done = 0, sum = 0, cout = 0
  - ra, rb, rs, c, cnt cleared
  - any in-flight addition is discarded with no done pulse

## Timing
- Edge E0 accepts start. busy is high after E0.
- Edges E1..E_WIDTH each process one bit, LSB first.
- sum, cout and done all update at E_WIDTH.
  - busy falls at E_WIDTH.
  - done is high for exactly the cycle between E_WIDTH and E_WIDTH+1.
- Latency: WIDTH+1 edges from accepting start to sampling done. For WIDTH=8, done is seen at E8.
- Throughput: one addition per WIDTH+1 cycles when start is held or re-pulsed in DONE.
- busy and done are never high together.
- sum and cout change only at a completion edge or on reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold rst 2 cycles with start=1 and random a/b -> busy=0, done=0, sum=0x00, cout=0. The first start after rst falls is accepted.
- Basic add (WIDTH=8): a=0x35, b=0x4A, cin=0, start at E0 -> busy=1 during E1..E8, done=1 after E8, sum=0x7F, cout=0.
- Carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Handshake: second start with a=0x01, b=0x01 pulsed at E3 of an op adding 0x10+0x20 -> ignored, result 0x30.
  - Then start held through DONE with a=0x02, b=0x03 -> re-accepted at E9, done after E17, sum=0x05.
- Reset mid-operation: rst asserted at E4 of 0x80+0x80 -> no done pulse, sum=0x00, cout=0, IDLE.
  - Next start with 0x01+0x02 -> sum=0x03 after 8 edges.
- WIDTH=1 instance: a=1, b=1, cin=0 -> done after E1, sum=0, cout=1. a=1, b=0, cin=1 -> sum=0, cout=1.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock through a half-adder pair plus OR.
// Latency WIDTH+1 edges from start to done; start is ignored while busy, so no backpressure beyond busy.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] ra, rb, rs, rs_next;
    logic            c, c_next, s;
    logic [CW-1:0]   cnt;
    logic            capture, step, finish;
    logic            p, g, t;

    // Full-adder slice: first cell forms propagate/generate, second folds in the carry.
    half_adder u_ha0 (.x(ra[0]), .y(rb[0]), .s(p), .c(g));
    half_adder u_ha1 (.x(p),     .y(c),     .s(s), .c(t));
    assign c_next = g | t;

    generate
        if (WIDTH == 1) begin : g_rs1
            assign rs_next = s;
        end else begin : g_rsn
            assign rs_next = {s, rs[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = ADD;
                end
            end
            ADD: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = ADD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ra   <= '0;
            rb   <= '0;
            rs   <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == ADD);
            done <= finish;
            if (capture) begin
                ra  <= a;
                rb  <= b;
                c   <= cin;
                cnt <= '0;
            end else if (step) begin
                ra  <= ra >> 1;
                rb  <= rb >> 1;
                rs  <= rs_next;
                c   <= c_next;
                cnt <= cnt + CW'(1);
            end
            // Result registers move only on the completing edge.
            if (finish) begin
                sum  <= rs_next;
                cout <= c_next;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       cin = 1'b0;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until done is seen on the selected instance; -1 if the budget expires.
    task automatic wait_done(input bit w1, input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if ((w1 ? done1 : done) === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        rst = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            cin = 1'($urandom);
            tick();
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
            n_checks++; if (sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum got %h want 00", sum); end
            n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", cout); end
            n_checks++; if ({busy1, done1, sum1, cout1} !== 4'b0) begin n_fail++; $display("FAIL reset_w1 got %b want 0000", {busy1, done1, sum1, cout1}); end
        end
        rst = 1'b0;
        a = 8'h35; b = 8'h4A; cin = 1'b0;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_start_accept busy got %b want 1", busy); end
        wait_done(1'b0, 20, lat);
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL first_start_latency got %0d want 8", lat); end
        n_checks++; if (sum !== 8'h7F) begin n_fail++; $display("FAIL first_start_sum got %h want 7f", sum); end
        tick();
    endtask

    task automatic test_basic();
        a = 8'h35; b = 8'h4A; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'hFF; b = 8'hFF; cin = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL basic_busy edge %0d got busy=%b done=%b want 1/0", e - 1, busy, done); end
            tick();
        end
        tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done_e8 got %b want 1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_e8 got %b want 0", busy); end
        n_checks++; if (sum !== 8'h7F) begin n_fail++; $display("FAIL basic_sum got %h want 7f", sum); end
        n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL basic_cout got %b want 0", cout); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", done); end
        n_checks++; if (sum !== 8'h7F) begin n_fail++; $display("FAIL basic_sum_hold got %h want 7f", sum); end
    endtask

    task automatic test_carry();
        int lat;
        a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b0, 20, lat);
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL carry1_latency got %0d want 8", lat); end
        n_checks++; if ({cout, sum} !== 9'h100) begin n_fail++; $display("FAIL carry1_result got %h want 100", {cout, sum}); end
        tick();
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b0, 20, lat);
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL carry2_latency got %0d want 8", lat); end
        n_checks++; if ({cout, sum} !== 9'h1FF) begin n_fail++; $display("FAIL carry2_result got %h want 1ff", {cout, sum}); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        tick();                                  // E0
        start = 1'b0; a = 8'h01; b = 8'h01;
        tick(); tick();                          // E1, E2
        start = 1'b1;
        tick();                                  // E3: start ignored
        start = 1'b0;
        tick(); tick(); tick(); tick();          // E4..E7
        start = 1'b1; a = 8'h02; b = 8'h03;
        tick();                                  // E8
        n_checks++; if (done !== 1'b1 || sum !== 8'h30) begin n_fail++; $display("FAIL ignore_start got done=%b sum=%h want 1/30", done, sum); end
        tick();                                  // E9: re-accepted from DONE
        start = 1'b0;
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got busy=%b done=%b want 1/0", busy, done); end
        n_checks++; if (sum !== 8'h30) begin n_fail++; $display("FAIL b2b_sum_hold got %h want 30", sum); end
        wait_done(1'b0, 20, lat);
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL b2b_latency got %0d want 8", lat); end
        n_checks++; if (sum !== 8'h05 || cout !== 1'b0) begin n_fail++; $display("FAIL b2b_sum got %h/%b want 05/0", sum, cout); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int pulses;
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();                                  // E4
        rst = 1'b0;
        n_checks++; if ({busy, done, cout, sum} !== 11'h000) begin n_fail++; $display("FAIL midrst_outputs got %h want 000", {busy, done, cout, sum}); end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_no_done got %0d active cycles want 0", pulses); end
        a = 8'h01; b = 8'h02; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b0, 20, lat);
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL midrst_next_latency got %0d want 8", lat); end
        n_checks++; if (sum !== 8'h03 || cout !== 1'b0) begin n_fail++; $display("FAIL midrst_next_sum got %h/%b want 03/0", sum, cout); end
        tick();
    endtask

    task automatic test_width1();
        int lat;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL w1_busy got %b want 1", busy1); end
        wait_done(1'b1, 5, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL w1a_latency got %0d want 1", lat); end
        n_checks++; if ({cout1, sum1} !== 2'b10) begin n_fail++; $display("FAIL w1a_result got %b want 10", {cout1, sum1}); end
        tick();
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_done(1'b1, 5, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL w1b_latency got %0d want 1", lat); end
        n_checks++; if ({cout1, sum1} !== 2'b10) begin n_fail++; $display("FAIL w1b_result got %b want 10", {cout1, sum1}); end
        tick();
    endtask

    // busy and done are never high together on either instance.
    always @(negedge clk) begin
        if (!rst && ((busy && done) || (busy1 && done1))) begin
            n_fail++;
            $display("FAIL busy_done_overlap got busy=%b done=%b busy1=%b done1=%b want exclusive", busy, done, busy1, done1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_reset_mid_op();
        test_width1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
